smem_result_writer: RTL

SMEM_RESULT_WRITER -- requirements
Module: smem_result_writer

---
 rtl/smem_result_writer_pkg.sv | 15 +
 rtl/sync_line_fifo.sv | 61 ++++++
 rtl/smem_result_writer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/smem_result_writer_pkg.sv
// Shared definitions for the result writer: line geometry and the batch FSM states.
package smem_result_writer_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_W     = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_STREAM,
        ST_STATUS,
        ST_DONE
    } wr_state_e;

endpackage

// File: rtl/sync_line_fifo.sv
// Synchronous first-word-fall-through line buffer; a push while full only lands
// when a pop frees the head slot in the same cycle.
module sync_line_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/smem_result_writer.sv
// Buffers upstream result lines and writes them to host memory after a reserved
// status line at base_addr; the status line is written last, once the batch drains.
module smem_result_writer
    import smem_result_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int SKID       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic              output_request,
    output logic              output_permit,
    input  logic              output_valid,
    input  logic [LINE_W-1:0] output_data,
    input  logic              output_finish,
    output logic              stall,
    output logic              wr_req,
    output logic [31:0]       wr_addr,
    output logic [LINE_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              done,
    output logic [15:0]       lines_written,
    output logic              overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - SKID);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    wr_state_e         state;
    wr_state_e         state_nxt;
    logic [31:0]       base_q;
    logic [31:0]       data_addr_q;
    logic [LINE_W-1:0] fifo_dout;
    logic [LINE_W-1:0] status_line;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              start_ok;
    logic              data_wr;
    logic              status_wr;
    logic              push;
    logic              pop;

    sync_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LINE_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (output_data),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // STATUS drains any line that slipped in alongside finish before the status write.
    assign start_ok      = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign data_wr       = ((state == ST_STREAM) || (state == ST_STATUS)) && !fifo_empty;
    assign status_wr     = (state == ST_STATUS) && fifo_empty;
    assign push          = (state == ST_STREAM) && output_valid;
    assign pop           = data_wr && wr_ready;
    assign output_permit = (state == ST_STREAM);
    assign wr_req        = data_wr || status_wr;
    assign status_line   = {{(LINE_W-17){1'b0}}, overflow, lines_written};

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (data_wr) begin
            wr_addr = data_addr_q;
            wr_data = fifo_dout;
        end else if (status_wr) begin
            wr_addr = base_q;
            wr_data = status_line;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start)                      state_nxt = ST_ARMED;
            ST_ARMED:         if (output_request)             state_nxt = ST_STREAM;
            ST_STREAM:        if (output_finish && fifo_empty) state_nxt = ST_STATUS;
            ST_STATUS:        if (status_wr && wr_ready)      state_nxt = ST_DONE;
            default:                                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            stall         <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            lines_written <= '0;
        end else begin
            state <= state_nxt;
            stall <= (fifo_count >= STALL_LVL);
            if (start_ok) begin
                done          <= 1'b0;
                overflow      <= 1'b0;
                lines_written <= '0;
            end else begin
                if (push && fifo_full && !pop) begin
                    overflow <= 1'b1;
                end
                if (pop) begin
                    lines_written <= sat_inc16(lines_written);
                end
                if (status_wr && wr_ready) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // Address registers are only observable while wr_req is high, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            base_q      <= base_addr;
            data_addr_q <= base_addr + 32'(LINE_BYTES);
        end else if (pop) begin
            data_addr_q <= data_addr_q + 32'(LINE_BYTES);
        end
    end

endmodule
